// File: rtl/input_debounce_pkg.sv
// Shared types and constants for the input_debounce block.
package input_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/input_debounce_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// d_i is captured on the first edge and reaches q_o after SYNC_STAGES edges.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw bit through the flop chain; oldest sample sits at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// Debouncer: synchronizer, counter-based stability filter, registered edge pulses.
// Optional glitch counter enabled by defining INPUT_DEBOUNCE_GLITCH_CNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// STABLE_LO | level_o = 0, synchronized input agrees
// WAIT_HI   | level_o = 0, input has been 1 for cnt consecutive enabled cycles
// STABLE_HI | level_o = 1, synchronized input agrees
// WAIT_LO   | level_o = 1, input has been 0 for cnt consecutive enabled cycles
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raw_i,
    input  logic                en_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o
`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr_i,
    output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("input_debounce: SYNC_STAGES must be >= 2");
        end
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("input_debounce: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    // Counter value at which the final agreeing cycle is reached.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (raw_i),
        .q_o  (sync_s)
    );

    // Stability filter: count consecutive enabled cycles that disagree with level_o.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (en_i && sync_s) begin
                    if (CNT_LAST == '0) begin
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HI;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!en_i || !sync_s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (en_i && !sync_s) begin
                    if (CNT_LAST == '0) begin
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LO;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (!en_i || sync_s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Filter state, level and edge pulses; reset drops any pending transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef INPUT_DEBOUNCE_GLITCH_CNT_EN
    logic                glitch_evt;
    logic [GLITCH_W-1:0] glitch_cnt_q;

    // Only a reverting input counts as a glitch; an en_i abort does not.
    assign glitch_evt = en_i && (((state_q == WAIT_HI) && !sync_s) ||
                                 ((state_q == WAIT_LO) &&  sync_s));

    // Saturating glitch counter; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_q <= '0;
        end else if (glitch_clr_i) begin
            glitch_cnt_q <= '0;
        end else if (glitch_evt && (glitch_cnt_q != '1)) begin
            glitch_cnt_q <= glitch_cnt_q + GLITCH_W'(1);
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule
